tc0200obj_ext_arbiter: RTL

- Owns the single port of the 4096x8 sprite code-extension RAM and shares it between the 68000 CPU window and the TC0200OBJ sprite fetch path.
- Sequences sprite code lookups and produces the widened 20-bit tile code.
- Serves CPU byte reads and writes with a level/ack handshake.
- Guarantees bounded CPU latency through a starvation counter.

---
 rtl/tc0200obj_ext_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tc0200obj_ext_arbiter.sv
// Single-port arbiter for the 4096x8 sprite code-extension RAM, shared between
// the 68000 CPU window and the TC0200OBJ sprite fetch path.
module tc0200obj_ext_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned CPU_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic              cpu_cs,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [1:0]        cpu_ds_n,
   input  logic              cpu_rw,
   input  logic [15:0]       cpu_din,
   output logic [15:0]       cpu_dout,
   output logic              cpu_ack,
   input  logic              obj_req,
   input  logic [14:0]       obj_addr,
   input  logic [13:0]       obj_code,
   output logic              obj_ack,
   output logic [19:0]       code_out,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_q
);

   localparam int unsigned SW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
   localparam logic [SW-1:0] MAX_WAIT = SW'(CPU_MAX_WAIT);

   typedef enum logic [2:0] {
      StIdle,
      StObjRd,
      StObjCap,
      StCpuRd,
      StCpuCap,
      StCpuWr,
      StCpuHold
   } state_e;

   state_e state_q, state_d;

   logic [SW-1:0]     starve_q, starve_d;
   logic              ext_q, ext_d;
   logic [13:0]       code_q, code_d;
   logic [15:0]       cpu_dout_d;
   logic              cpu_ack_d;
   logic              obj_ack_d;
   logic [19:0]       code_out_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic              ram_we_d;
   logic [7:0]        ram_din_d;

   logic cpu_pend;
   logic obj_grant;
   logic cpu_grant;
   logic ext_mode;
   logic unused_bits;

   assign unused_bits = ^{cpu_ds_n[1], cpu_din[15:8], obj_addr[2:0]};

   assign ext_mode  = (mode == 2'b01);
   assign cpu_pend  = cpu_cs && !cpu_ack && (state_q != StCpuHold);
   assign obj_grant = (state_q == StIdle) && obj_req && (!cpu_pend || (starve_q < MAX_WAIT));
   assign cpu_grant = (state_q == StIdle) && !obj_grant && cpu_pend;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         starve_q <= '0;
         ext_q    <= 1'b0;
         code_q   <= '0;
         cpu_dout <= '0;
         cpu_ack  <= 1'b0;
         obj_ack  <= 1'b0;
         code_out <= '0;
         ram_addr <= '0;
         ram_we   <= 1'b0;
         ram_din  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         ext_q    <= ext_d;
         code_q   <= code_d;
         cpu_dout <= cpu_dout_d;
         cpu_ack  <= cpu_ack_d;
         obj_ack  <= obj_ack_d;
         code_out <= code_out_d;
         ram_addr <= ram_addr_d;
         ram_we   <= ram_we_d;
         ram_din  <= ram_din_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (obj_grant) begin
               state_d = ext_mode ? StObjRd : StObjCap;
            end else if (cpu_grant) begin
               state_d = cpu_rw ? StCpuRd : StCpuWr;
            end
         end
         StObjRd:   state_d = StObjCap;
         StObjCap:  state_d = StIdle;
         StCpuRd:   state_d = cpu_cs ? StCpuCap : StIdle;
         StCpuCap:  state_d = cpu_cs ? StCpuHold : StIdle;
         StCpuWr:   state_d = cpu_cs ? StCpuHold : StIdle;
         StCpuHold: state_d = cpu_cs ? StCpuHold : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      starve_d   = starve_q;
      ext_d      = ext_q;
      code_d     = code_q;
      cpu_dout_d = cpu_dout;
      cpu_ack_d  = cpu_ack;
      obj_ack_d  = 1'b0;
      code_out_d = code_out;
      ram_addr_d = ram_addr;
      ram_we_d   = 1'b0;
      ram_din_d  = ram_din;
      case (state_q)
         StIdle: begin
            if (obj_grant) begin
               ext_d  = ext_mode;
               code_d = obj_code;
               // Passthrough leaves the RAM address untouched.
               if (ext_mode) begin
                  ram_addr_d = ADDR_W'(obj_addr[14:3]);
               end
               if (cpu_pend && (starve_q < MAX_WAIT)) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (cpu_grant) begin
               starve_d   = '0;
               ram_addr_d = cpu_addr;
               if (!cpu_rw) begin
                  ram_we_d  = !cpu_ds_n[0];
                  ram_din_d = cpu_din[7:0];
               end
            end
         end
         StObjCap: begin
            obj_ack_d  = 1'b1;
            code_out_d = ext_q ? {4'd0, ram_q, code_q[7:0]} : {6'd0, code_q};
         end
         StCpuCap: begin
            if (cpu_cs) begin
               cpu_dout_d = {ram_q, ram_q};
               cpu_ack_d  = 1'b1;
            end
         end
         StCpuWr: begin
            if (cpu_cs) begin
               cpu_ack_d = 1'b1;
            end
         end
         StCpuHold: begin
            if (!cpu_cs) begin
               cpu_ack_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule
